y86_regfile_sb: RTL



---
 rtl/y86_pkg.sv | 36 +++
 rtl/y86_en_reg.sv | 19 +
 rtl/y86_pend_ctr.sv | 33 +++
 rtl/y86_regfile_sb.sv | 129 ++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 pipeline: register indices, the
// "no register" index, default data width and a ceiling-log2 helper.
package y86_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int AW_DEF    = 4;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] RAX = 4'd0;
  localparam logic [3:0] RCX = 4'd1;
  localparam logic [3:0] RDX = 4'd2;
  localparam logic [3:0] RBX = 4'd3;
  localparam logic [3:0] RSP = 4'd4;
  localparam logic [3:0] RBP = 4'd5;
  localparam logic [3:0] RSI = 4'd6;
  localparam logic [3:0] RDI = 4'd7;
  localparam logic [3:0] R8  = 4'd8;
  localparam logic [3:0] R9  = 4'd9;
  localparam logic [3:0] R10 = 4'd10;
  localparam logic [3:0] R11 = 4'd11;
  localparam logic [3:0] R12 = 4'd12;
  localparam logic [3:0] R13 = 4'd13;
  localparam logic [3:0] R14 = 4'd14;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/y86_en_reg.sv
// Enable/reset register primitive: loads d when en, RSTVAL on reset.
module y86_en_reg #(
  parameter int           W      = 64,
  parameter logic [W-1:0] RSTVAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage with synchronous reset dominating the load enable.
  always_ff @(posedge clock) begin
    if (reset)   q <= RSTVAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/y86_pend_ctr.sv
// Saturating pending-write counter for one register. Simultaneous inc and
// dec cancel; inc at MAXPEND and dec at zero are dropped and flagged.
module y86_pend_ctr #(
  parameter int MAXPEND = 3,
  parameter int CW      = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic zero,
  output logic err
);

  logic [CW-1:0] count;

  assign full = (count == CW'(MAXPEND));
  assign zero = (count == '0);
  assign err  = (inc & ~dec & full) | (dec & ~inc & zero);

  // Count claims up and releases down, holding at both limits.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + CW'(1);
    end else if (dec && !inc && !zero) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/y86_regfile_sb.sv
// Y86-64 register file with two read ports, two writeback ports, optional
// same-cycle write-through bypass and a per-register pending-write
// scoreboard that decode uses to detect read-after-write hazards.
module y86_regfile_sb
  import y86_pkg::*;
#(
  parameter int               WIDTH    = WIDTH_DEF,
  parameter int               NREG     = 15,
  parameter int               AW       = AW_DEF,
  parameter logic [WIDTH-1:0] RESETVAL = '0,
  parameter int               BYPASS   = 1,
  parameter int               MAXPEND  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [AW-1:0]         srcA,
  input  logic [AW-1:0]         srcB,
  output logic [WIDTH-1:0]      valA,
  output logic [WIDTH-1:0]      valB,
  output logic                  pendA,
  output logic                  pendB,
  input  logic [AW-1:0]         dstE,
  input  logic [WIDTH-1:0]      valE,
  input  logic [AW-1:0]         dstM,
  input  logic [WIDTH-1:0]      valM,
  input  logic                  clm_en,
  input  logic [AW-1:0]         clmE,
  input  logic [AW-1:0]         clmM,
  input  logic                  rel_en,
  output logic                  sb_full,
  output logic                  sb_err,
  output logic [WIDTH*NREG-1:0] dbg_regs
);

  localparam int CW_RAW = clog2(MAXPEND + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

  logic [NREG-1:0] claim_v;
  logic [NREG-1:0] rel_v;
  logic [NREG-1:0] full_v;
  logic [NREG-1:0] zero_v;
  logic [NREG-1:0] err_v;

  // Indices at or above NREG (RNONE included) name no register.
  function automatic logic idx_ok(input logic [AW-1:0] idx);
    return 32'(idx) < NREG;
  endfunction

  // Bypass: M beats E so a dual write to one register (popq %rsp) reads valM.
  function automatic logic [WIDTH-1:0] fwd(input logic [AW-1:0]    src,
                                           input logic [WIDTH-1:0] stored);
    logic [WIDTH-1:0] r;
    r = stored;
    if (BYPASS != 0 && idx_ok(src)) begin
      if (src == dstM)      r = valM;
      else if (src == dstE) r = valE;
    end
    return r;
  endfunction

  genvar i;
  generate
    for (i = 0; i < NREG; i++) begin : g_reg
      logic wr_e;
      logic wr_m;
      assign wr_e = (dstE == AW'(i));
      assign wr_m = (dstM == AW'(i));

      // Duplicate indices within a claim or release pair count once.
      assign claim_v[i] = clm_en & ((clmE == AW'(i)) | (clmM == AW'(i)));
      assign rel_v[i]   = rel_en & (wr_e | wr_m);

      y86_en_reg #(
        .W      (WIDTH),
        .RSTVAL (RESETVAL)
      ) u_reg (
        .clock (clock),
        .reset (reset),
        .en    (wr_e | wr_m),
        .d     (wr_m ? valM : valE),
        .q     (dbg_regs[i*WIDTH +: WIDTH])
      );

      y86_pend_ctr #(
        .MAXPEND (MAXPEND),
        .CW      (CW)
      ) u_ctr (
        .clock (clock),
        .reset (reset),
        .inc   (claim_v[i]),
        .dec   (rel_v[i]),
        .full  (full_v[i]),
        .zero  (zero_v[i]),
        .err   (err_v[i])
      );
    end
  endgenerate

  assign sb_full = |(claim_v & full_v);

  // Read ports: select stored value and pending flag, then apply bypass.
  always_comb begin
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    sa    = '0;
    sb    = '0;
    pendA = 1'b0;
    pendB = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      if (srcA == AW'(k)) begin
        sa    = dbg_regs[k*WIDTH +: WIDTH];
        pendA = ~zero_v[k];
      end
      if (srcB == AW'(k)) begin
        sb    = dbg_regs[k*WIDTH +: WIDTH];
        pendB = ~zero_v[k];
      end
    end
    valA = fwd(srcA, sa);
    valB = fwd(srcB, sb);
  end

  // Sticky scoreboard error, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset)       sb_err <= 1'b0;
    else if (|err_v) sb_err <= 1'b1;
  end

endmodule
